// File: rtl/board_link_pkg.sv
// Shared constants and types for the inter-board checkers link.
package board_link_pkg;

  // One board frame: 8 rows of 32 bits, each square encoded in 4 bits.
  localparam int FRAME_BITS  = 256;
  localparam int ROW_BITS    = 32;
  localparam int SQUARE_BITS = 4;

  // Receiver timing defaults.
  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // Width of the bit counter (must be able to hold FRAME_BITS itself).
  localparam int BIT_COUNT_W = 9;

  // Receiver states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/board_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line plus a rising-edge detector.
module sync_edge #(
  parameter int SYNC_STAGES = board_link_pkg::DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async line through the synchroniser and remember the last synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/board_rx.sv
// Serial receive stage: deserialises one board frame from the peer's
// clkIn/dataIn lines and presents it on receiveBuffer with a newData strobe.
module board_rx #(
  parameter int FRAME_BITS     = board_link_pkg::FRAME_BITS,
  parameter int SYNC_STAGES    = board_link_pkg::DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = board_link_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clkIn,
  input  logic                  dataIn,
  input  logic                  readyForSend,
  output logic                  readyForReceive,
  output logic [FRAME_BITS-1:0] receiveBuffer,
  output logic                  newData,
  output logic                  frameError,
  output logic                  busy,
  output logic [8:0]            bitCount
);

  import board_link_pkg::*;

  localparam int         WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] BC_LAST = 9'(FRAME_BITS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Synchronised peer lines.
  logic                   w_clk_level;
  logic                   w_clk_rise_raw;
  logic                   w_clk_rise;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_rfs_sync;
  logic                   w_bit;
  logic                   w_rfs;

  // Receiver state and datapath registers.
  rx_state_t              r_state;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [8:0]             r_bit_count;
  logic [WD_W-1:0]        r_watchdog;
  logic [FRAME_BITS-1:0]  r_rx_buf;
  logic                   r_new_data;
  logic                   r_frame_err;
  logic                   r_ready;
  logic                   r_busy;

  // Next-state values.
  rx_state_t              w_state_next;
  logic [FRAME_BITS-1:0]  w_shift_next;
  logic [8:0]             w_bit_count_next;
  logic [WD_W-1:0]        w_watchdog_next;
  logic [FRAME_BITS-1:0]  w_rx_buf_next;
  logic                   w_new_data_next;
  logic                   w_frame_err_next;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (clkIn),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise_raw)
  );

  // A rise is only meaningful while the synced clock level is high.
  assign w_clk_rise = w_clk_rise_raw & w_clk_level;

  // Level synchronisers for data and readyForSend, same depth as the clock path
  // so the sampled bit lines up with the detected edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_sync <= '0;
      r_rfs_sync  <= '0;
    end else begin
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], dataIn};
      r_rfs_sync  <= {r_rfs_sync[SYNC_STAGES-2:0], readyForSend};
    end
  end

  assign w_bit = r_data_sync[SYNC_STAGES-1];
  assign w_rfs = r_rfs_sync[SYNC_STAGES-1];

  // Next-state and datapath decisions for the receive FSM.
  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_count_next = r_bit_count;
    w_watchdog_next  = r_watchdog;
    w_rx_buf_next    = r_rx_buf;
    w_new_data_next  = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_bit_count_next = 9'd0;
        w_watchdog_next  = '0;
        if (enable) begin
          w_state_next = READY;
        end else begin
          w_state_next = IDLE;
        end
      end

      READY: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if (w_clk_rise && w_rfs) begin
          // First bit of the frame lands in bit 0.
          w_state_next     = SHIFT;
          w_shift_next     = {{(FRAME_BITS-1){1'b0}}, w_bit};
          w_bit_count_next = 9'd1;
          w_watchdog_next  = '0;
        end else begin
          w_state_next = READY;
        end
      end

      SHIFT: begin
        if (!w_rfs) begin
          // Peer gave up mid-frame; any bit arriving in this cycle is dropped.
          w_state_next     = IDLE;
          w_shift_next     = '0;
          w_bit_count_next = 9'd0;
          w_watchdog_next  = '0;
          w_frame_err_next = 1'b1;
        end else if (w_clk_rise) begin
          w_shift_next     = {r_shift[FRAME_BITS-2:0], w_bit};
          w_bit_count_next = r_bit_count + 9'd1;
          w_watchdog_next  = '0;
          if (r_bit_count == BC_LAST) begin
            w_state_next = DONE;
          end else begin
            w_state_next = SHIFT;
          end
        end else if (r_watchdog == WD_LAST) begin
          // This is the TIMEOUT_CYCLES-th consecutive cycle without an edge.
          w_state_next     = IDLE;
          w_shift_next     = '0;
          w_bit_count_next = 9'd0;
          w_watchdog_next  = '0;
          w_frame_err_next = 1'b1;
        end else begin
          w_watchdog_next = r_watchdog + {{(WD_W-1){1'b0}}, 1'b1};
          w_state_next    = SHIFT;
        end
      end

      DONE: begin
        w_rx_buf_next    = r_shift;
        w_new_data_next  = 1'b1;
        w_bit_count_next = 9'd0;
        w_watchdog_next  = '0;
        if (enable) begin
          w_state_next = READY;
        end else begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next     = IDLE;
        w_shift_next     = '0;
        w_bit_count_next = 9'd0;
        w_watchdog_next  = '0;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_count <= 9'd0;
      r_watchdog  <= '0;
      r_rx_buf    <= '0;
      r_new_data  <= 1'b0;
      r_frame_err <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_count <= w_bit_count_next;
      r_watchdog  <= w_watchdog_next;
      r_rx_buf    <= w_rx_buf_next;
      r_new_data  <= w_new_data_next;
      r_frame_err <= w_frame_err_next;
      r_ready     <= (w_state_next == READY) || (w_state_next == SHIFT);
      r_busy      <= (w_state_next == SHIFT);
    end
  end

  assign readyForReceive = r_ready;
  assign receiveBuffer   = r_rx_buf;
  assign newData         = r_new_data;
  assign frameError      = r_frame_err;
  assign busy            = r_busy;
  assign bitCount        = r_bit_count;

endmodule

// File: tb/tb_board_rx.sv
// Self-checking bench for board_rx: directed scenarios plus random frames,
// compared against a frame-level model of what the receiver should deliver.
module tb_board_rx;

  localparam int FB = 256;
  localparam int TO = 4096;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          clkIn;
  logic          dataIn;
  logic          readyForSend;
  logic          readyForReceive;
  logic [FB-1:0] receiveBuffer;
  logic          newData;
  logic          frameError;
  logic          busy;
  logic [8:0]    bitCount;

  board_rx #(
    .FRAME_BITS     (FB),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .clkIn           (clkIn),
    .dataIn          (dataIn),
    .readyForSend    (readyForSend),
    .readyForReceive (readyForReceive),
    .receiveBuffer   (receiveBuffer),
    .newData         (newData),
    .frameError      (frameError),
    .busy            (busy),
    .bitCount        (bitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Monitor state, sampled on the falling edge away from the active edge.
  int       cyc          = 0;
  int       nd_cnt       = 0;
  int       fe_cnt       = 0;
  int       fe_gap       = -1;
  int       last_inc_cyc = 0;
  logic [8:0] prev_bc    = 9'd0;
  logic [2:0] rfr_h      = 3'b000;
  logic [2:0] nd_hist    = 3'b000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (newData) begin
      nd_cnt  <= nd_cnt + 1;
      nd_hist <= {rfr_h[1:0], readyForReceive};
    end
    if (frameError) begin
      fe_cnt <= fe_cnt + 1;
      fe_gap <= cyc - last_inc_cyc;
    end
    if (bitCount > prev_bc) last_inc_cyc <= cyc;
    prev_bc <= bitCount;
    rfr_h   <= {rfr_h[1:0], readyForReceive};
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peer transmitter: MSB first, data set during the low phase, sampled on the rise.
  task automatic send_bits(input logic [FB-1:0] f, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      dataIn = f[FB-1-i];
      clkIn  = 1'b0;
      step(half);
      clkIn  = 1'b1;
      step(half);
    end
    clkIn = 1'b0;
    step(half);
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] r;
    for (int i = 0; i < FB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  logic [FB-1:0] exp_buf;
  logic [FB-1:0] pat;
  logic [FB-1:0] ones;
  logic [FB-1:0] alt;
  logic [FB-1:0] frm;
  int            nd0;
  int            fe0;
  int            half;

  initial begin
    pat  = {32'h03030303, 32'h30303030, 32'h03030303, 32'h00000000,
            32'h00000000, 32'h10101010, 32'h01010101, 32'h00010101};
    ones = '1;
    for (int i = 0; i < FB / 8; i++) alt[i*8 +: 8] = 8'hAA;
    exp_buf = '0;

    rst = 1'b1; enable = 1'b0; clkIn = 1'b0; dataIn = 1'b0; readyForSend = 1'b0;

    // Reset
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_rfr",   FB'(readyForReceive), FB'(0));
    check("rst_buf",   receiveBuffer,        exp_buf);
    check("rst_nd",    FB'(newData),         FB'(0));
    check("rst_fe",    FB'(frameError),      FB'(0));
    check("rst_busy",  FB'(busy),            FB'(0));
    check("rst_bc",    FB'(bitCount),        FB'(0));
    readyForSend = 1'b1;
    send_bits(rand_frame(), 6, 4);
    check("idle_bc", FB'(bitCount), FB'(0));
    check("idle_rfr", FB'(readyForReceive), FB'(0));

    // Full frame of the test board pattern
    enable = 1'b1;
    step(6);
    check("ready_rfr", FB'(readyForReceive), FB'(1));
    nd0 = nd_cnt; fe0 = fe_cnt;
    send_bits(pat, FB, 8);
    step(4);
    exp_buf = pat;
    check("full_nd",   FB'(nd_cnt - nd0), FB'(1));
    check("full_fe",   FB'(fe_cnt - fe0), FB'(0));
    check("full_buf",  receiveBuffer,     exp_buf);
    check("full_rfr_hist", FB'(nd_hist),  FB'(3'b101));
    check("full_bc",   FB'(bitCount),     FB'(0));

    // Abort by dropping readyForSend after bit 100
    nd0 = nd_cnt; fe0 = fe_cnt;
    send_bits(rand_frame(), 100, 6);
    check("abort_bc_mid", FB'(bitCount), FB'(100));
    check("abort_busy_mid", FB'(busy), FB'(1));
    readyForSend = 1'b0;
    step(10);
    check("abort_fe",  FB'(fe_cnt - fe0), FB'(1));
    check("abort_nd",  FB'(nd_cnt - nd0), FB'(0));
    check("abort_bc",  FB'(bitCount),     FB'(0));
    check("abort_buf", receiveBuffer,     exp_buf);

    // Watchdog timeout after bit 37
    readyForSend = 1'b1;
    step(6);
    nd0 = nd_cnt; fe0 = fe_cnt;
    send_bits(rand_frame(), 37, 5);
    enable = 1'b0;
    step(TO + 20);
    check("to_fe",   FB'(fe_cnt - fe0), FB'(1));
    check("to_gap",  FB'(fe_gap),       FB'(TO));
    check("to_nd",   FB'(nd_cnt - nd0), FB'(0));
    check("to_rfr",  FB'(readyForReceive), FB'(0));
    check("to_busy", FB'(busy),         FB'(0));
    check("to_buf",  receiveBuffer,     exp_buf);

    // Reset in the middle of a frame
    enable = 1'b1;
    step(6);
    nd0 = nd_cnt; fe0 = fe_cnt;
    send_bits(rand_frame(), 200, 5);
    rst = 1'b1;
    step(1);
    exp_buf = '0;
    check("mrst_buf",  receiveBuffer,       exp_buf);
    check("mrst_bc",   FB'(bitCount),       FB'(0));
    check("mrst_busy", FB'(busy),           FB'(0));
    check("mrst_rfr",  FB'(readyForReceive), FB'(0));
    rst = 1'b0;
    step(4);
    check("mrst_pulses", FB'((nd_cnt - nd0) + (fe_cnt - fe0)), FB'(0));
    frm = rand_frame();
    nd0 = nd_cnt;
    send_bits(frm, FB, 8);
    step(4);
    exp_buf = frm;
    check("post_rst_nd",  FB'(nd_cnt - nd0), FB'(1));
    check("post_rst_buf", receiveBuffer,     exp_buf);

    // Back-to-back frames with a short readyForSend gap
    nd0 = nd_cnt; fe0 = fe_cnt;
    send_bits(ones, FB, 4);
    step(4);
    exp_buf = ones;
    check("b2b1_nd",  FB'(nd_cnt - nd0), FB'(1));
    check("b2b1_buf", receiveBuffer,     exp_buf);
    readyForSend = 1'b0;
    step(4);
    readyForSend = 1'b1;
    send_bits(alt, FB, 4);
    step(4);
    exp_buf = alt;
    check("b2b2_nd",  FB'(nd_cnt - nd0), FB'(2));
    check("b2b2_buf", receiveBuffer,     exp_buf);
    check("b2b_fe",   FB'(fe_cnt - fe0), FB'(0));

    // Random frames at random legal serial rates
    for (int k = 0; k < 3; k++) begin
      frm  = rand_frame();
      half = $urandom_range(7, 4);
      readyForSend = 1'b0;
      step($urandom_range(8, 3));
      readyForSend = 1'b1;
      nd0 = nd_cnt; fe0 = fe_cnt;
      send_bits(frm, FB, half);
      step(4);
      exp_buf = frm;
      check("rand_nd",  FB'(nd_cnt - nd0), FB'(1));
      check("rand_fe",  FB'(fe_cnt - fe0), FB'(0));
      check("rand_buf", receiveBuffer,     exp_buf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
